imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that sits directly upstream of the fetch stage. It accepts a stream of 32-bit instruction words from the bench or host and writes them into instruction memory through the fetch stage's write port (`wdata_i`/`wen_i`). It holds the core in reset until the whole image has been written, and optionally checksum-verified. It then releases the core to fetch from word address 0.

## Interface
Parameters:
- `DATA_WIDTH`, 32: instruction/data word width (equals `core::DATA_WIDTH`).
- `DATA_BYTES`, 4: byte enables per word (`DATA_WIDTH/8`).
- `ADDR_WIDTH`, 10: instruction memory word-address width; capacity is `2**ADDR_WIDTH` words.

Ports:
- `clk`, in, 1: core clock; all logic is on the rising edge.
- `rst`, in, 1: one clock; reset is synchronous and active-high.
- `start_i`, in, 1: load request, sampled in IDLE, RUN and ERR.
- `len_i`, in, ADDR_WIDTH+1: image length in words, sampled together with `start_i`.
- `s_valid_i`, in, 1: stream word valid.
- `s_data_i`, in, DATA_WIDTH: stream word.
- `s_ready_o`, out, 1: loader accepts a stream word this cycle.
- `wdata_o`, out, DATA_WIDTH: write data to the fetch stage `wdata_i`.
- `waddr_o`, out, ADDR_WIDTH: word write address.
- `wen_o`, out, DATA_BYTES: byte write enables to the fetch stage `wen_i`.
- `core_rst_o`, out, 1: 1 = hold the pipeline (fetch PC, stages) in reset.
- `done_o`, out, 1: the image is loaded and the core is running.
- `err_o`, out, 1: the load failed (bad length or checksum mismatch).
- `words_o`, out, ADDR_WIDTH+1: number of words written in the current or last load.

## Operation
- States: IDLE, LOAD, CHECK (compiled only with the macro), RUN, ERR.
- IDLE:
  - `core_rst_o`=1, `s_ready_o`=0.
  - `start_i`=1 with `1 <= len_i <= 2**ADDR_WIDTH`: latch the length, clear `words_o` and the checksum, go to LOAD.
  - `start_i`=1 with `len_i`=0 or `len_i > 2**ADDR_WIDTH`: go to ERR.
- LOAD:
  - `s_ready_o`=1 (driven from the state register, not from `s_valid_i`).
  - Each handshake (`s_valid_i & s_ready_o`) registers `wdata_o`=`s_data_i`, `waddr_o`=`words_o[ADDR_WIDTH-1:0]`, `wen_o`=all ones for exactly one cycle, and increments `words_o`.
  - `start_i` is ignored.
  - When the handshake carries word number `len`, the next state is CHECK (macro) or RUN.
- CHECK: `s_ready_o`=1. The next handshake carries the trailer word and is not written to memory. Trailer equal to the checksum: go to RUN. Otherwise: go to ERR.
- RUN:
  - `core_rst_o`=0, `done_o`=1.
  - `start_i`=1 re-enters LOAD with the new length (or ERR if the length is bad). `core_rst_o` reasserts on the same edge.
- ERR:
  - `err_o`=1, `core_rst_o`=1.
  - `start_i` behaves as in IDLE and clears `err_o`.
- `wen_o` is 0 in every cycle that has no handshake in the previous cycle, and is never asserted for the trailer.
- `words_o` saturates at `len`. It wraps into `waddr_o` only through its low ADDR_WIDTH bits; when `len = 2**ADDR_WIDTH`, the last address is `2**ADDR_WIDTH-1`.
- A reset during LOAD or CHECK returns to IDLE. Memory contents already written are not cleared.

## Timing
- Reset values: `s_ready_o`=0, `wdata_o`=0, `waddr_o`=0, `wen_o`=0, `core_rst_o`=1, `done_o`=0, `err_o`=0, `words_o`=0.
- Write latency: handshake at edge N produces `wen_o` asserted during cycle N+1. At full rate this gives one word per cycle with no bubbles.
- Release timing:
  - `core_rst_o` falls on the edge after the final memory write is presented, so the last word is committed before the first fetch.
  - Without the macro: last handshake at edge N, then `wen_o` during N+1, then `core_rst_o`=0 from edge N+1.
- `s_ready_o` deasserts on the same edge that leaves LOAD or CHECK. The loader never accepts a word beyond `len` (+1 trailer).

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - CHECK state is compiled in.
  - Running checksum per accepted word: `csum = {csum[DATA_WIDTH-2:0], csum[DATA_WIDTH-1]} ^ word`, starting from 0.
  - One trailer word is expected after the image and compared against `csum`.
- Undefined: no CHECK state and no trailer. LOAD goes straight to RUN, and `err_o` is raised only for a bad length.

## Test plan
- Reset, then `start_i` with `len_i`=4, stream 0x00000013, 0x00100093, 0x00200113, 0x002081B3 back-to-back -> `wen_o`=4'hF on 4 consecutive cycles at addresses 0..3; `words_o`=4; `core_rst_o`=0 and `done_o`=1 (without the macro).
- Same image with `s_valid_i` toggling every other cycle -> same writes spaced by bubbles, no duplicate or dropped words, `wen_o`=0 in the bubble cycles.
- `len_i`=0, and separately `len_i`=2**ADDR_WIDTH+1 -> ERR, `err_o`=1, `core_rst_o`=1, no writes. A following valid `start_i` clears `err_o`.
- With the macro: 2 words 0x1, 0x2 followed by trailer 0x00000000 -> RUN. The same words followed by trailer 0x4 -> ERR. Trailer is never written.
- `rst` asserted after 2 of 4 words -> IDLE next cycle, all outputs at reset values, `s_ready_o`=0.
- `start_i` in RUN with `len_i`=1 -> `core_rst_o` rises on the same edge, one word is written at address 0, then the core is released again.

Source files
------------

// File: rtl/imem_loader.sv
// Streams a program image into instruction memory and holds the core in reset until it is loaded.
// Optional trailer checksum verification is compiled in with `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH:0]     len_i,
    input  logic                    s_valid_i,
    input  logic [DATA_WIDTH-1:0]   s_data_i,
    output logic                    s_ready_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [ADDR_WIDTH-1:0]   waddr_o,
    output logic [DATA_BYTES-1:0]   wen_o,
    output logic                    core_rst_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [ADDR_WIDTH:0]     words_o
);

    localparam int unsigned LW = ADDR_WIDTH + 1;
    localparam logic [LW-1:0] MAX_LEN = LW'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_RUN,
        S_ERR
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [LW-1:0]   len_q;
    logic            hs;
    logic            len_ok;
    logic            last_word;
    logic            load_go;
    logic            wen_d;
    logic            ready_d;
    logic            core_rst_d;
    logic            done_d;
    logic            err_d;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum;
    logic                  trailer_ok;
    assign trailer_ok = (s_data_i == csum);
`endif

    assign hs        = s_valid_i & s_ready_o;
    assign len_ok    = (len_i != '0) && (len_i <= MAX_LEN);
    assign last_word = ((words_o + LW'(1)) == len_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_RUN, S_ERR: begin
                if (start_i) begin
                    state_next = len_ok ? S_LOAD : S_ERR;
                end
            end
            S_LOAD: begin
                if (hs && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = S_CHECK;
`else
                    state_next = S_RUN;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (hs) begin
                    state_next = trailer_ok ? S_RUN : S_ERR;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode; the core is released only one edge after RUN is entered
    always_comb begin
        wen_d      = hs && (state == S_LOAD);
        load_go    = (state_next == S_LOAD) && (state != S_LOAD);
        ready_d    = (state_next == S_LOAD);
`ifdef IMEM_LOADER_CHECKSUM_EN
        ready_d    = ready_d || (state_next == S_CHECK);
`endif
        core_rst_d = !((state == S_RUN) && (state_next == S_RUN));
        done_d     = !core_rst_d;
        err_d      = (state_next == S_ERR);
    end

    // Registered outputs and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready_o  <= 1'b0;
            wdata_o    <= '0;
            waddr_o    <= '0;
            wen_o      <= '0;
            core_rst_o <= 1'b1;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            words_o    <= '0;
            len_q      <= '0;
        end else begin
            s_ready_o  <= ready_d;
            core_rst_o <= core_rst_d;
            done_o     <= done_d;
            err_o      <= err_d;
            wen_o      <= {DATA_BYTES{wen_d}};
            if (wen_d) begin
                wdata_o <= s_data_i;
                waddr_o <= words_o[ADDR_WIDTH-1:0];
            end
            if (load_go) begin
                len_q   <= len_i;
                words_o <= '0;
            end else if (wen_d && (words_o != len_q)) begin
                words_o <= words_o + LW'(1);
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Rotate-left-by-one then XOR running checksum over accepted image words
    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= '0;
        end else if (load_go) begin
            csum <= '0;
        end else if (wen_d) begin
            csum <= {csum[DATA_WIDTH-2:0], csum[DATA_WIDTH-1]} ^ s_data_i;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a queue-based image model.
module tb_imem_loader;

    localparam int unsigned DW    = 32;
    localparam int unsigned DB    = 4;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic [AW:0]       len_i;
    logic              s_valid_i;
    logic [DW-1:0]     s_data_i;
    logic              s_ready_o;
    logic [DW-1:0]     wdata_o;
    logic [AW-1:0]     waddr_o;
    logic [DB-1:0]     wen_o;
    logic              core_rst_o;
    logic              done_o;
    logic              err_o;
    logic [AW:0]       words_o;

    imem_loader #(.DATA_WIDTH(DW), .DATA_BYTES(DB), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .len_i      (len_i),
        .s_valid_i  (s_valid_i),
        .s_data_i   (s_data_i),
        .s_ready_o  (s_ready_o),
        .wdata_o    (wdata_o),
        .waddr_o    (waddr_o),
        .wen_o      (wen_o),
        .core_rst_o (core_rst_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .words_o    (words_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DB-1:0] wen;
    } wr_t;

    wr_t obs[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory-side monitor: every presented write
    always @(negedge clk) begin
        if (wen_o != '0) obs.push_back('{cyc, waddr_o, wdata_o, wen_o});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 64'(s_ready_o), 0);
        check({tag, "_wdata"}, 64'(wdata_o), 0);
        check({tag, "_waddr"}, 64'(waddr_o), 0);
        check({tag, "_wen"}, 64'(wen_o), 0);
        check({tag, "_core_rst"}, 64'(core_rst_o), 1);
        check({tag, "_done"}, 64'(done_o), 0);
        check({tag, "_err"}, 64'(err_o), 0);
        check({tag, "_words"}, 64'(words_o), 0);
    endtask

    task automatic do_start(input logic [AW:0] len);
        @(negedge clk);
        start_i = 1'b1;
        len_i   = len;
        @(negedge clk);
        start_i = 1'b0;
        len_i   = $urandom;
    endtask

    // gap: 0 = full rate, 1 = valid every other cycle, 2 = random bubbles
    task automatic stream(input logic [DW-1:0] w[$], input int gap);
        int  i = 0;
        int  budget = 0;
        bit  on;
        while (i < w.size() && budget < 4 * w.size() + 20) begin
            on = (gap == 0) ? 1'b1 : (gap == 1) ? (budget % 2 == 0) : ($urandom_range(0, 2) != 0);
            s_valid_i = on;
            s_data_i  = on ? w[i] : $urandom;
            if (on && s_ready_o) i++;
            @(negedge clk);
            budget++;
        end
        s_valid_i = 1'b0;
        check("stream_budget", 64'(i), 64'(w.size()));
    endtask

    task automatic load_and_check(input string tag, input logic [DW-1:0] w[$], input int gap,
                                  input bit corrupt);
        logic [DW-1:0] s[$];
        logic [DW-1:0] c = '0;
        bit            bad = 1'b0;
        int            n;
        s = w;
        foreach (w[k]) c = ((c << 1) | (c >> (DW - 1))) ^ w[k];
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(corrupt ? (c ^ 32'h4) : c);
        bad = corrupt;
`else
        c = c ^ DW'(corrupt);
`endif
        obs.delete();
        do_start((AW + 1)'(w.size()));
        check({tag, "_start_err"}, 64'(err_o), 0);
        check({tag, "_start_rst"}, 64'(core_rst_o), 1);
        check({tag, "_start_ready"}, 64'(s_ready_o), 1);
        stream(s, gap);
        // keep offering words: none may be accepted past the image
        s_valid_i = 1'b1;
        s_data_i  = $urandom;
        check({tag, "_ready_drop"}, 64'(s_ready_o), 0);
        check({tag, "_rst_hold"}, 64'(core_rst_o), 1);
        @(negedge clk);
        check({tag, "_core_rst"}, 64'(core_rst_o), 64'(bad));
        check({tag, "_done"}, 64'(done_o), 64'(!bad));
        check({tag, "_err"}, 64'(err_o), 64'(bad));
        repeat (2) @(negedge clk);
        s_valid_i = 1'b0;
        check({tag, "_words"}, 64'(words_o), 64'(w.size()));
        check({tag, "_nwrites"}, 64'(obs.size()), 64'(w.size()));
        n = (obs.size() < w.size()) ? obs.size() : w.size();
        for (int k = 0; k < n; k++) begin
            check({tag, "_addr"}, 64'(obs[k].addr), 64'(AW'(k % DEPTH)));
            check({tag, "_data"}, 64'(obs[k].data), 64'(w[k]));
            check({tag, "_wen"}, 64'(obs[k].wen), 64'({DB{1'b1}}));
            if (k > 0 && gap < 2)
                check({tag, "_spacing"}, 64'(obs[k].cyc - obs[k-1].cyc), 64'(gap + 1));
        end
    endtask

    task automatic bad_len(input string tag, input logic [AW:0] len);
        obs.delete();
        do_start(len);
        check({tag, "_err"}, 64'(err_o), 1);
        check({tag, "_core_rst"}, 64'(core_rst_o), 1);
        check({tag, "_ready"}, 64'(s_ready_o), 0);
        repeat (2) @(negedge clk);
        check({tag, "_nwrites"}, 64'(obs.size()), 0);
    endtask

    initial begin
        logic [DW-1:0] img[$];
        logic [DW-1:0] rnd[$];
        rst       = 1'b1;
        start_i   = 1'b0;
        len_i     = '0;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        img = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h002081B3};
        load_and_check("full", img, 0, 1'b0);
        load_and_check("bubble", img, 1, 1'b0);
        rnd = '{32'h0};
        rnd[0] = $urandom;
        load_and_check("run_restart", rnd, 0, 1'b0);

        bad_len("len0", '0);
        bad_len("len_over", (AW + 1)'(DEPTH + 1));
        load_and_check("err_clear", img, 0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        load_and_check("csum_ok", '{32'h1, 32'h2}, 0, 1'b0);
        load_and_check("csum_bad", '{32'h1, 32'h2}, 0, 1'b1);
`endif

        // reset during LOAD after two of four words
        do_start(4);
        stream('{img[0], img[1]}, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("midrst");

        for (int r = 0; r < 6; r++) begin
            rnd.delete();
            repeat ($urandom_range(1, 24)) rnd.push_back($urandom);
            load_and_check("rand", rnd, 2, 1'b0);
        end

        rnd.delete();
        for (int k = 0; k < DEPTH; k++) rnd.push_back($urandom);
        load_and_check("fullmem", rnd, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
